pll_lock_reset_gen: RTL and testbench
=====================================

Name: pll_lock_reset_gen

Overview:
- Consumes the PLL lock indication and produces a clean, synchronous, active-low reset and ready flag for logic in the PLL output domains (DDR/memory controller, video pipeline).
- Runs on the free-running 27 MHz crystal clock, never on a PLL output, so it keeps operating while the PLL is unlocked.
- Requires lock to be stable before release.
- Detects lock loss, re-asserts reset, and records loss events for debug/status readout.

Parameters:
- STABLE_CYCLES, 1024, consecutive synchronized-lock-high cycles required before reset release (>=2).
- RELEASE_CYCLES, 256, cycles between sys_rst_n rising and ready rising (>=1).
- CNT_W, 16, width of the internal cycle counter; must hold max(STABLE_CYCLES, RELEASE_CYCLES)-1.
- EVT_W, 8, width of the loss-event counter.

Ports:
- clk  in  1  27 MHz crystal reference clock (same source as the PLL input).
- rst_n  in  1  asynchronous active-low reset.
- pll_lock  in  1  PLL lock, asynchronous to clk.
- clr_status  in  1  synchronous clear of lost_flag and loss_cnt.
- sys_rst_n  out  1  registered active-low reset for downstream logic.
- ready  out  1  downstream may start traffic.
- lost_flag  out  1  sticky: lock was lost after release.
- loss_cnt  out  EVT_W  saturating count of lock-loss events.

Behaviour:
- Reset (rst_n=0, async):
  - sys_rst_n=0, ready=0, lost_flag=0, loss_cnt=0.
  - Synchronizer flops=0, counter=0, state=WAIT_LOCK.
- Synchronizer: pll_lock passes through 2 flops to give lock_s; 2-edge latency. No other logic samples pll_lock directly.
- All outputs are registered and change only on clk rising edges.
- States: WAIT_LOCK, STABLE, DEASSERT, RUN, LOST.
- WAIT_LOCK:
  - cnt=0; sys_rst_n=0; ready=0.
  - If lock_s=1, go to STABLE.
- STABLE:
  - If lock_s=0, go to WAIT_LOCK and clear cnt. Not a loss event.
  - Otherwise cnt increments.
  - When cnt==STABLE_CYCLES-1 and lock_s=1: go to DEASSERT, clear cnt, sys_rst_n<=1.
- DEASSERT:
  - sys_rst_n=1; cnt increments.
  - When cnt==RELEASE_CYCLES-1: go to RUN, ready<=1.
- RUN: sys_rst_n=1, ready=1. Holds indefinitely while lock_s=1.
- Loss (lock_s=0 seen in DEASSERT or RUN): on the same edge that leaves the state:
  - state<=LOST, sys_rst_n<=0, ready<=0.
  - lost_flag<=1.
  - loss_cnt<=loss_cnt+1, saturating at all-ones.
- LOST: unconditionally go to WAIT_LOCK next edge. cnt=0. Guarantees a minimum 2-cycle reset pulse.
- Latency: pll_lock rising, stable and meeting setup at edge E0:
  - sys_rst_n rises at edge E0+STABLE_CYCLES+2. (This is the edge on which STABLE reaches cnt==STABLE_CYCLES-1 and exits to DEASSERT.)
  - ready rises RELEASE_CYCLES edges later.
- Loss latency: pll_lock falling to sys_rst_n low is at most 3 edges.
- clr_status:
  - Clears lost_flag and loss_cnt on the next edge.
  - If a loss event occurs on the same edge, the event wins: lost_flag=1, loss_cnt=1.
- Glitch on pll_lock shorter than one clk period may or may not be captured. Either outcome must leave the FSM in a legal state.
- Illegal/unused state encodings recover to WAIT_LOCK with sys_rst_n=0 and ready=0.
- Invariant: ready=1 implies sys_rst_n=1.

Decomposition:
- Shared package pll_rst_pkg: state enum (WAIT_LOCK, STABLE, DEASSERT, RUN, LOST) with explicit encoding; default STABLE_CYCLES/RELEASE_CYCLES constants for the 27 MHz board.
- One sub-module, sync_2ff: generic 2-flop synchronizer with async active-low reset and reset value 0. It is reused by other CDC points in the design.

Test Plan (STABLE_CYCLES=16, RELEASE_CYCLES=8 unless noted):
- Power-up: rst_n low 5 cycles with pll_lock=1, then release. Required:
  - all outputs 0 during reset;
  - sys_rst_n=1 exactly 18 edges after the first edge sampling pll_lock=1;
  - ready=1 8 edges later;
  - lost_flag=0, loss_cnt=0.
- Unstable lock: pll_lock high 10 cycles, low 3, then high permanently. Required:
  - no sys_rst_n release during the first pulse;
  - the release timing restarts from the second rise;
  - loss_cnt stays 0.
- Loss in RUN: drop pll_lock for 4 cycles after ready=1. Required:
  - sys_rst_n=0 and ready=0 within 3 edges;
  - lost_flag=1, loss_cnt=1;
  - full 18+8 edge re-release after pll_lock returns.
- Loss during DEASSERT: drop pll_lock 3 edges after sys_rst_n rises. Required: ready never asserts; loss_cnt increments to 1.
- Status clear: clr_status pulse with no event clears to lost_flag=0, loss_cnt=0. clr_status coincident with a loss edge gives lost_flag=1, loss_cnt=1.
- Saturation: EVT_W=2, force 5 loss events. Required: loss_cnt sticks at 3.
- Async reset mid-RUN: rst_n asserted asynchronously. Required: outputs go low without waiting for a clk edge.

Source files
------------

// File: rtl/pll_rst_pkg.sv
// Shared types and board defaults for the PLL lock / reset generator.
package pll_rst_pkg;

  // Explicit encoding; the three unused codes fall into the FSM default branch.
  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    DEASSERT  = 3'd2,
    RUN       = 3'd3,
    LOST      = 3'd4
  } pll_state_e;

  // 27 MHz crystal: ~38 us of stable lock, then ~9.5 us of reset-released settle.
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_RELEASE_CYCLES = 256;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer, async active-low reset, resets to 0.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_reset_gen.sv
// Turns an asynchronous PLL lock into a qualified downstream reset and ready,
// and keeps sticky/saturating records of lock loss after release.
module pll_lock_reset_gen
  import pll_rst_pkg::*;
#(
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int RELEASE_CYCLES = DEF_RELEASE_CYCLES,
  parameter int CNT_W          = 16,
  parameter int EVT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             clr_status,
  output logic             sys_rst_n,
  output logic             ready,
  output logic             lost_flag,
  output logic [EVT_W-1:0] loss_cnt
);

  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);
  localparam logic [EVT_W-1:0] EVT_MAX      = '1;
  localparam logic [EVT_W-1:0] EVT_ONE      = EVT_W'(1);

  logic             lock_s;
  pll_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             loss_evt;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  // A loss only counts once the downstream reset has been released.
  always_comb loss_evt = ((state == DEASSERT) || (state == RUN)) && !lock_s;

  // Sequencer: qualify lock, release reset, then raise ready; drop both on loss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_LOCK;
      cnt       <= '0;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          cnt       <= '0;
          sys_rst_n <= 1'b0;
          ready     <= 1'b0;
          if (lock_s) state <= STABLE;
        end
        STABLE: begin
          sys_rst_n <= 1'b0;
          ready     <= 1'b0;
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state     <= DEASSERT;
            cnt       <= '0;
            sys_rst_n <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DEASSERT: begin
          if (loss_evt) begin
            state     <= LOST;
            cnt       <= '0;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
          end else if (cnt == RELEASE_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            sys_rst_n <= 1'b1;
            ready     <= 1'b1;
          end else begin
            cnt       <= cnt + 1'b1;
            sys_rst_n <= 1'b1;
            ready     <= 1'b0;
          end
        end
        RUN: begin
          cnt <= '0;
          if (loss_evt) begin
            state     <= LOST;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
          end else begin
            sys_rst_n <= 1'b1;
            ready     <= 1'b1;
          end
        end
        LOST: begin
          // One forced cycle here makes the reset pulse at least two cycles long.
          state     <= WAIT_LOCK;
          cnt       <= '0;
          sys_rst_n <= 1'b0;
          ready     <= 1'b0;
        end
        default: begin
          state     <= WAIT_LOCK;
          cnt       <= '0;
          sys_rst_n <= 1'b0;
          ready     <= 1'b0;
        end
      endcase
    end
  end

  // Status: a loss on the same edge as a clear wins and restarts the count at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost_flag <= 1'b0;
      loss_cnt  <= '0;
    end else if (loss_evt) begin
      lost_flag <= 1'b1;
      if (clr_status)             loss_cnt <= EVT_ONE;
      else if (loss_cnt != EVT_MAX) loss_cnt <= loss_cnt + 1'b1;
    end else if (clr_status) begin
      lost_flag <= 1'b0;
      loss_cnt  <= '0;
    end
  end

endmodule

// File: tb/tb_pll_lock_reset_gen.sv
// Bench for pll_lock_reset_gen: hand-derived vector table, corner sequences,
// and randomized lock activity against a run-length reference model.
module tb_pll_lock_reset_gen;

  localparam int S = 16;
  localparam int R = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b1;
  logic       clr_status = 1'b0;
  logic       sys8, rdy8, lost8;
  logic [7:0] cnt8;
  logic       sys2, rdy2, lost2;
  logic [1:0] cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: sync pipeline, length of the current lock_s-high run,
  // a one-edge blackout after a loss, and unsaturated event count.
  logic m_s1, m_s2;
  int   m_n, m_evt;
  bit   m_bo, m_lost;

  always #5 clk = ~clk;

  pll_lock_reset_gen #(.STABLE_CYCLES(S), .RELEASE_CYCLES(R), .CNT_W(16), .EVT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .clr_status(clr_status),
    .sys_rst_n(sys8), .ready(rdy8), .lost_flag(lost8), .loss_cnt(cnt8));

  pll_lock_reset_gen #(.STABLE_CYCLES(S), .RELEASE_CYCLES(R), .CNT_W(16), .EVT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .clr_status(clr_status),
    .sys_rst_n(sys2), .ready(rdy2), .lost_flag(lost2), .loss_cnt(cnt2));

  typedef struct {
    logic lock;
    logic clr;
    int   cyc;
    logic sys;
    logic rdy;
    logic lost;
    int   cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_n = 0; m_bo = 0; m_lost = 0; m_evt = 0;
  endtask

  task automatic model_edge(input logic lk, input logic cl);
    logic ls;
    bit   ev;
    ls = m_s2; m_s2 = m_s1; m_s1 = lk; ev = 0;
    if (m_bo) begin
      m_bo = 0; m_n = 0;
    end else if (ls) begin
      if (m_n < 100000) m_n++;
    end else begin
      if (m_n >= S + 1) begin ev = 1; m_bo = 1; end
      m_n = 0;
    end
    if (ev) begin
      m_lost = 1;
      m_evt  = cl ? 1 : m_evt + 1;
    end else if (cl) begin
      m_lost = 0; m_evt = 0;
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk_model();
    logic es, er;
    es = (m_n >= S + 1);
    er = (m_n >= S + 1 + R);
    chk("m_sys8",  32'(sys8),  32'(es));
    chk("m_rdy8",  32'(rdy8),  32'(er));
    chk("m_lost8", 32'(lost8), 32'(m_lost));
    chk("m_cnt8",  32'(cnt8),  32'(sat(m_evt, 255)));
    chk("m_sys2",  32'(sys2),  32'(es));
    chk("m_rdy2",  32'(rdy2),  32'(er));
    chk("m_lost2", 32'(lost2), 32'(m_lost));
    chk("m_cnt2",  32'(cnt2),  32'(sat(m_evt, 3)));
  endtask

  // Inputs change at negedge; outputs are checked on the following negedge.
  task automatic step(input logic lk, input logic cl);
    pll_lock = lk; clr_status = cl;
    @(posedge clk);
    model_edge(lk, cl);
    @(negedge clk);
    chk_model();
  endtask

  task automatic steps(input logic lk, input int n);
    for (int i = 0; i < n; i++) step(lk, 1'b0);
  endtask

  initial begin
    int   lvl, run;
    logic saw_rdy;

    // Table: hand-derived outputs after each record (S=16, R=8).
    tbl.push_back('{1, 0, 18, 0, 0, 0, 0}); // power-up, still qualifying
    tbl.push_back('{1, 0,  1, 1, 0, 0, 0}); // release 18 edges after first sample
    tbl.push_back('{1, 0,  7, 1, 0, 0, 0});
    tbl.push_back('{1, 0,  1, 1, 1, 0, 0}); // ready 8 edges later
    tbl.push_back('{1, 0,  5, 1, 1, 0, 0});
    tbl.push_back('{0, 0,  2, 1, 1, 0, 0}); // loss in RUN, sync latency
    tbl.push_back('{0, 0,  1, 0, 0, 1, 1}); // dropped on third edge
    tbl.push_back('{0, 0,  1, 0, 0, 1, 1});
    tbl.push_back('{1, 0, 18, 0, 0, 1, 1}); // full re-qualification
    tbl.push_back('{1, 0,  1, 1, 0, 1, 1});
    tbl.push_back('{1, 0,  7, 1, 0, 1, 1});
    tbl.push_back('{1, 0,  1, 1, 1, 1, 1});
    tbl.push_back('{1, 1,  1, 1, 1, 0, 0}); // clear with no event
    tbl.push_back('{1, 0,  2, 1, 1, 0, 0});
    tbl.push_back('{0, 0,  4, 0, 0, 1, 1}); // loss
    tbl.push_back('{1, 0, 10, 0, 0, 1, 1}); // unstable first pulse
    tbl.push_back('{0, 0,  3, 0, 0, 1, 1});
    tbl.push_back('{1, 0, 18, 0, 0, 1, 1}); // timing restarts from second rise
    tbl.push_back('{1, 0,  1, 1, 0, 1, 1});
    tbl.push_back('{1, 0,  8, 1, 1, 1, 1});

    // Power-up reset with lock already high.
    model_reset();
    repeat (5) @(negedge clk);
    chk("rst_sys8", 32'(sys8), 0);  chk("rst_rdy8", 32'(rdy8), 0);
    chk("rst_lost8", 32'(lost8), 0); chk("rst_cnt8", 32'(cnt8), 0);
    chk("rst_sys2", 32'(sys2), 0);  chk("rst_cnt2", 32'(cnt2), 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].cyc; c++) step(tbl[i].lock, (c == 0) ? tbl[i].clr : 1'b0);
      chk($sformatf("tbl%0d_sys", i),  32'(sys8),  32'(tbl[i].sys));
      chk($sformatf("tbl%0d_rdy", i),  32'(rdy8),  32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_lost", i), 32'(lost8), 32'(tbl[i].lost));
      chk($sformatf("tbl%0d_cnt", i),  32'(cnt8),  32'(tbl[i].cnt));
    end

    // Loss during DEASSERT, with a clear landing on the loss edge.
    steps(1'b0, 4);                       // second event -> count 2
    chk("pre_deassert_cnt", 32'(cnt8), 2);
    steps(1'b1, 19);
    chk("deassert_sys_up", 32'(sys8), 1);
    saw_rdy = 1'b0;
    step(1'b1, 1'b0); step(1'b1, 1'b0);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    saw_rdy |= rdy8;
    step(1'b0, 1'b1);                     // loss edge and clear together
    chk("clr_vs_loss_lost", 32'(lost8), 1);
    chk("clr_vs_loss_cnt",  32'(cnt8), 1);
    chk("deassert_sys_down", 32'(sys8), 0);
    for (int i = 0; i < 10; i++) begin step(1'b0, 1'b0); saw_rdy |= rdy8; end
    chk("deassert_no_ready", 32'(saw_rdy), 0);

    // Saturation of the narrow counter over five events.
    step(1'b0, 1'b1);
    chk("sat_clr_cnt", 32'(cnt2), 0);
    for (int e = 0; e < 5; e++) begin
      steps(1'b1, 20);
      steps(1'b0, 4);
    end
    chk("sat_cnt2", 32'(cnt2), 3);
    chk("sat_cnt8", 32'(cnt8), 5);
    chk("sat_lost2", 32'(lost2), 1);

    // Asynchronous reset in RUN, checked before any clock edge.
    steps(1'b1, 30);
    chk("run_rdy", 32'(rdy8), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sys8", 32'(sys8), 0);  chk("arst_rdy8", 32'(rdy8), 0);
    chk("arst_lost8", 32'(lost8), 0); chk("arst_cnt8", 32'(cnt8), 0);
    chk("arst_sys2", 32'(sys2), 0);  chk("arst_cnt2", 32'(cnt2), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Random lock runs and sporadic status clears.
    lvl = 1;
    for (int blk = 0; blk < 150; blk++) begin
      run = lvl ? $urandom_range(1, 40) : $urandom_range(1, 6);
      for (int c = 0; c < run; c++) step(lvl[0], ($urandom_range(0, 15) == 0));
      lvl = 1 - lvl;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
